// File: rtl/zigbee_pkg.sv
// Shared types and widths for the pad-bus time-multiplexing scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package zigbee_pkg;

  localparam int NB_BANKS = 4;
  localparam int IN_W     = 22;
  localparam int OUT_W    = 18;

  typedef logic [1:0] bank_id_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } pad_sched_state_t;

  // One-hot strobe for a bank index.
  function automatic logic [NB_BANKS-1:0] bank_onehot(input bank_id_t b);
    return NB_BANKS'(1) << b;
  endfunction

endpackage

// File: rtl/zigbee_rr_arbiter.sv
// Four-way round-robin arbiter; the bank after the last winner has top priority.
// Latency: grant is combinational from req_i; the pointer moves on the advance strobe edge.
// Backpressure: none; the grant is only consumed when adv_i is high.
module zigbee_rr_arbiter
  import zigbee_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NB_BANKS-1:0] req_i,
  input  logic                adv_i,
  output logic [NB_BANKS-1:0] gnt_o,
  output bank_id_t            gnt_idx_o,
  output bank_id_t            ptr_o
);

  bank_id_t ptr_q, ptr_d;
  bank_id_t gnt_idx;
  logic     found;

  // Scan requests starting at the pointer, wrapping upward.
  always_comb begin
    bank_id_t idx;
    found   = 1'b0;
    gnt_idx = ptr_q;
    idx     = ptr_q;
    for (int i = 0; i < NB_BANKS; i++) begin
      idx = bank_id_t'(ptr_q + bank_id_t'(i));
      if (!found && req_i[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // Pointer moves to one past the winner only when a grant is actually taken.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && found) begin
      ptr_d = bank_id_t'(gnt_idx + 2'd1);
    end
  end

  // Pointer register; reset makes bank 0 the first winner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o     = found ? bank_onehot(gnt_idx) : '0;
  assign gnt_idx_o = gnt_idx;
  assign ptr_o     = ptr_q;

endmodule

// File: rtl/zigbee_pad_scheduler.sv
// Time-multiplexes the shared pad bus among four banks: select, drive, settle, capture.
// Latency: sel/pad_out at t+1 after request, capture at t+dwell+2, in_valid at t+dwell+3.
// Backpressure: none; banks hold req_i level until out_ready_o/in_valid_o pulse.
module zigbee_pad_scheduler
  import zigbee_pkg::*;
#(
  parameter int NB_BANKS = zigbee_pkg::NB_BANKS,
  parameter int IN_W     = zigbee_pkg::IN_W,
  parameter int OUT_W    = zigbee_pkg::OUT_W,
  parameter int DWELL_W  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DWELL_W-1:0]        dwell_i,
  input  logic [NB_BANKS-1:0]       req_i,
  input  logic [NB_BANKS*OUT_W-1:0] out_data_i,
  output logic [NB_BANKS-1:0]       out_ready_o,
  input  logic [IN_W-1:0]           pad_in_i,
  output logic [OUT_W-1:0]          pad_out_o,
  output logic [1:0]                sel_o,
  output logic [IN_W-1:0]           in_data_o,
  output logic [NB_BANKS-1:0]       in_valid_o,
  output logic                      busy_o
);

  pad_sched_state_t    state_q, state_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  bank_id_t            sel_q, sel_d;
  logic [OUT_W-1:0]    pad_out_q, pad_out_d;
  logic [IN_W-1:0]     in_data_q, in_data_d;
  logic [NB_BANKS-1:0] in_valid_q, in_valid_d;
  logic [NB_BANKS-1:0] out_ready_q, out_ready_d;

  logic                adv;
  logic [NB_BANKS-1:0] gnt_vec;
  bank_id_t            gnt_idx;
  bank_id_t            rr_ptr;

  zigbee_rr_arbiter u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .adv_i     (adv),
    .gnt_o     (gnt_vec),
    .gnt_idx_o (gnt_idx),
    .ptr_o     (rr_ptr)
  );

  // Next-state logic: slot sequencing plus grant load from IDLE or SAMPLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    pad_out_d   = pad_out_q;
    in_data_d   = in_data_q;
    in_valid_d  = '0;
    out_ready_d = '0;
    adv         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        adv = |req_i;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      ST_SAMPLE: begin
        // sel_q still names the owning bank here; it only moves on the next grant.
        in_data_d  = pad_in_i;
        in_valid_d = bank_onehot(sel_q);
        state_d    = ST_IDLE;
        adv        = |req_i;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Grant load: dwell and output word are latched here and never re-read mid-slot.
    if (adv) begin
      state_d     = ST_SETTLE;
      cnt_d       = dwell_i;
      sel_d       = gnt_idx;
      pad_out_d   = out_data_i[int'(gnt_idx)*OUT_W +: OUT_W];
      out_ready_d = gnt_vec;
    end
  end

  // State and registered outputs; reset aborts any slot in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      pad_out_q   <= '0;
      in_data_q   <= '0;
      in_valid_q  <= '0;
      out_ready_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      pad_out_q   <= pad_out_d;
      in_data_q   <= in_data_d;
      in_valid_q  <= in_valid_d;
      out_ready_q <= out_ready_d;
    end
  end

  // The bank under the pointer always has top priority when it requests.
  a_ptr_priority : assert property (@(posedge clk_i) disable iff (rst_i)
    (adv && req_i[rr_ptr]) |-> (gnt_idx == rr_ptr));

  assign sel_o       = sel_q;
  assign pad_out_o   = pad_out_q;
  assign in_data_o   = in_data_q;
  assign in_valid_o  = in_valid_q;
  assign out_ready_o = out_ready_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_zigbee_pad_scheduler.sv
// Self-checking bench for the pad scheduler: scoreboard of out_ready/in_valid events.
// Latency: expected event cycles derived from request cycle and dwell.
// Backpressure: n/a.
module tb_zigbee_pad_scheduler;

  typedef struct packed {
    logic        kind;   // 0 = out_ready pulse, 1 = in_valid pulse
    logic [3:0]  vec;
    logic [1:0]  sel;
    logic [21:0] data;
    logic [31:0] cyc;
  } ev_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [3:0]    dwell_i = '0;
  logic [3:0]    req_i = '0;
  logic [71:0]   out_data_i = '0;
  logic [3:0]    out_ready_o;
  logic [21:0]   pad_in_i = '0;
  logic [17:0]   pad_out_o;
  logic [1:0]    sel_o;
  logic [21:0]   in_data_o;
  logic [3:0]    in_valid_o;
  logic          busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t e, o;

  logic [17:0] dat [4];

  zigbee_pad_scheduler dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .dwell_i     (dwell_i),
    .req_i       (req_i),
    .out_data_i  (out_data_i),
    .out_ready_o (out_ready_o),
    .pad_in_i    (pad_in_i),
    .pad_out_o   (pad_out_o),
    .sel_o       (sel_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Record every output pulse with the cycle it was seen in.
  always @(negedge clk_i) begin
    if (out_ready_o !== 4'b0) obs_q.push_back(ev_t'{1'b0, out_ready_o, sel_o, {4'b0, pad_out_o}, 32'(cyc)});
    if (in_valid_o !== 4'b0)  obs_q.push_back(ev_t'{1'b1, in_valid_o, 2'b0, in_data_o, 32'(cyc)});
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_i = '0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic exp_or(input int b, input logic [17:0] d, input int c);
    exp_q.push_back(ev_t'{1'b0, 4'(4'b0001 << b), 2'(b), {4'b0, d}, 32'(c)});
  endtask

  task automatic exp_iv(input int b, input logic [21:0] d, input int c);
    exp_q.push_back(ev_t'{1'b1, 4'(4'b0001 << b), 2'b0, d, 32'(c)});
  endtask

  task automatic load_data();
    out_data_i = {dat[3], dat[2], dat[1], dat[0]};
  endtask

  task automatic test_reset();
    do_reset();
    rst_i = 1'b1;
    step();
    total++; if (sel_o !== 2'd0) begin bad++; $display("FAIL rst_sel: got %0d want 0", sel_o); end
    total++; if (pad_out_o !== 18'h0) begin bad++; $display("FAIL rst_pad_out: got %h want 0", pad_out_o); end
    total++; if (in_data_o !== 22'h0) begin bad++; $display("FAIL rst_in_data: got %h want 0", in_data_o); end
    total++; if (in_valid_o !== 4'b0) begin bad++; $display("FAIL rst_in_valid: got %b want 0000", in_valid_o); end
    total++; if (out_ready_o !== 4'b0) begin bad++; $display("FAIL rst_out_ready: got %b want 0000", out_ready_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_single();
    int t;
    exp_q.delete(); obs_q.delete();
    dwell_i = 4'd3;
    dat[1] = 18'h2A5A5; load_data();
    pad_in_i = 22'h155AA5;
    step(); t = cyc;
    req_i = 4'b0010;
    exp_or(1, 18'h2A5A5, t + 1);
    exp_iv(1, 22'h155AA5, t + 6);
    step(); req_i = 4'b0000;
    total++; if (sel_o !== 2'd1 || pad_out_o !== 18'h2A5A5) begin bad++; $display("FAIL single_drive: got sel=%0d pad=%h want sel=1 pad=2a5a5", sel_o, pad_out_o); end
    repeat (8) step();
    total++; if (busy_o !== 1'b0 || sel_o !== 2'd1 || in_data_o !== 22'h155AA5) begin bad++; $display("FAIL single_hold: got busy=%b sel=%0d in=%h want 0/1/155aa5", busy_o, sel_o, in_data_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL single_ev: got none, want kind=%0d vec=%b cyc=%0d", e.kind, e.vec, e.cyc); end
      else begin o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL single_ev: got k=%0d v=%b s=%0d d=%h c=%0d want k=%0d v=%b s=%0d d=%h c=%0d", o.kind, o.vec, o.sel, o.data, o.cyc, e.kind, e.vec, e.sel, e.data, e.cyc); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL single_extra: got %0d extra events want 0", obs_q.size()); end
  endtask

  task automatic test_all_four();
    int t;
    do_reset();
    exp_q.delete(); obs_q.delete();
    dwell_i = 4'd0;
    load_data();
    pad_in_i = 22'h0ABCDE;
    step(); t = cyc;
    req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_or(k % 4, dat[k % 4], t + 1 + 2 * k);
      if (k > 0) exp_iv((k - 1) % 4, 22'h0ABCDE, t + 1 + 2 * k);
    end
    exp_iv(0, 22'h0ABCDE, t + 11);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 9) req_i = 4'b0000;
      total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL all4_busy: got %b want 1 at offset %0d", busy_o, k); end
    end
    repeat (4) step();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL all4_idle: got %b want 0", busy_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL all4_ev: got none, want kind=%0d vec=%b cyc=%0d", e.kind, e.vec, e.cyc); end
      else begin o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL all4_ev: got k=%0d v=%b s=%0d d=%h c=%0d want k=%0d v=%b s=%0d d=%h c=%0d", o.kind, o.vec, o.sel, o.data, o.cyc, e.kind, e.vec, e.sel, e.data, e.cyc); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL all4_extra: got %0d extra events want 0", obs_q.size()); end
  endtask

  task automatic test_rotation();
    int t;
    do_reset();
    exp_q.delete(); obs_q.delete();
    dwell_i = 4'd0;
    pad_in_i = 22'h33C3C3;
    step(); t = cyc;
    req_i = 4'b0001;
    exp_or(0, dat[0], t + 1);
    exp_or(3, dat[3], t + 3); exp_iv(0, 22'h33C3C3, t + 3);
    exp_or(0, dat[0], t + 5); exp_iv(3, 22'h33C3C3, t + 5);
    exp_iv(0, 22'h33C3C3, t + 7);
    step(); req_i = 4'b1001;
    repeat (4) step();
    req_i = 4'b0000;
    repeat (5) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL rot_ev: got none, want kind=%0d vec=%b cyc=%0d", e.kind, e.vec, e.cyc); end
      else begin o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL rot_ev: got k=%0d v=%b s=%0d d=%h c=%0d want k=%0d v=%b s=%0d d=%h c=%0d", o.kind, o.vec, o.sel, o.data, o.cyc, e.kind, e.vec, e.sel, e.data, e.cyc); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rot_extra: got %0d extra events want 0", obs_q.size()); end
  endtask

  task automatic test_sampling();
    int t;
    logic [17:0] orig;
    exp_q.delete(); obs_q.delete();
    orig = dat[2];
    load_data();
    dwell_i = 4'd5;
    pad_in_i = 22'h111111;
    step(); t = cyc;
    req_i = 4'b0100;
    exp_or(2, orig, t + 1);
    exp_iv(2, 22'h2BEEF5, t + 8);
    step();
    req_i = 4'b0000; dwell_i = 4'd1;
    out_data_i[2*18 +: 18] = 18'h0DEAD;
    step(); step();
    pad_in_i = 22'h222222;
    total++; if (pad_out_o !== orig) begin bad++; $display("FAIL samp_pad_out: got %h want %h", pad_out_o, orig); end
    repeat (4) step();
    pad_in_i = 22'h2BEEF5;
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL samp_busy: got %b want 1", busy_o); end
    step();
    pad_in_i = 22'h3C3C3C;
    repeat (4) step();
    total++; if (in_data_o !== 22'h2BEEF5) begin bad++; $display("FAIL samp_hold: got %h want 2beef5", in_data_o); end
    load_data();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL samp_ev: got none, want kind=%0d vec=%b cyc=%0d", e.kind, e.vec, e.cyc); end
      else begin o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL samp_ev: got k=%0d v=%b s=%0d d=%h c=%0d want k=%0d v=%b s=%0d d=%h c=%0d", o.kind, o.vec, o.sel, o.data, o.cyc, e.kind, e.vec, e.sel, e.data, e.cyc); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL samp_extra: got %0d extra events want 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid();
    int t, u;
    exp_q.delete(); obs_q.delete();
    load_data();
    dwell_i = 4'd4;
    pad_in_i = 22'h0F0F0F;
    step(); t = cyc;
    req_i = 4'b0100;
    exp_or(2, dat[2], t + 1);
    step(); req_i = 4'b0000;
    step(); rst_i = 1'b1;
    step(); rst_i = 1'b0;
    total++; if (sel_o !== 2'd0 || pad_out_o !== 18'h0 || busy_o !== 1'b0) begin bad++; $display("FAIL rmid_outputs: got sel=%0d pad=%h busy=%b want 0/0/0", sel_o, pad_out_o, busy_o); end
    repeat (8) step();
    u = cyc;
    dwell_i = 4'd0;
    req_i = 4'b1111;
    exp_or(0, dat[0], u + 1);
    exp_iv(0, 22'h0F0F0F, u + 3);
    step(); req_i = 4'b0000;
    repeat (5) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL rmid_ev: got none, want kind=%0d vec=%b cyc=%0d", e.kind, e.vec, e.cyc); end
      else begin o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL rmid_ev: got k=%0d v=%b s=%0d d=%h c=%0d want k=%0d v=%b s=%0d d=%h c=%0d", o.kind, o.vec, o.sel, o.data, o.cyc, e.kind, e.vec, e.sel, e.data, e.cyc); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rmid_extra: got %0d extra events want 0", obs_q.size()); end
  endtask

  task automatic test_withdraw();
    int t;
    exp_q.delete(); obs_q.delete();
    load_data();
    dwell_i = 4'd2;
    pad_in_i = 22'h2468AC;
    step(); t = cyc;
    req_i = 4'b0100;
    exp_or(2, dat[2], t + 1);
    exp_iv(2, 22'h2468AC, t + 5);
    step();
    step(); req_i = 4'b0000;
    repeat (5) step();
    total++; if (sel_o !== 2'd2 || busy_o !== 1'b0) begin bad++; $display("FAIL wd_idle: got sel=%0d busy=%b want sel=2 busy=0", sel_o, busy_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL wd_ev: got none, want kind=%0d vec=%b cyc=%0d", e.kind, e.vec, e.cyc); end
      else begin o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL wd_ev: got k=%0d v=%b s=%0d d=%h c=%0d want k=%0d v=%b s=%0d d=%h c=%0d", o.kind, o.vec, o.sel, o.data, o.cyc, e.kind, e.vec, e.sel, e.data, e.cyc); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL wd_extra: got %0d extra events want 0", obs_q.size()); end
  endtask

  initial begin
    dat[0] = 18'h00011;
    dat[1] = 18'h12345;
    dat[2] = 18'h2ABCD;
    dat[3] = 18'h3F00F;
    load_data();
    test_reset();
    test_single();
    test_all_four();
    test_rotation();
    test_sampling();
    test_reset_mid();
    test_withdraw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
